lane_serializer: RTL and testbench

//   Downstream stage of the 12-lane mod4Bports pipeline: accepts each parallel
//   12-bit lane word (OA at bit 0 ... OL at bit 11), buffers it in a small FIFO
//   and emits it as a framed serial bitstream with valid/ready flow control.

---
 rtl/lane_serializer.sv | 227 ++++++++++++++++++++++
 tb/tb_lane_serializer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_serializer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// lane_serializer
//
// Purpose
//   Takes parallel N_LANES-bit lane words (lane OA at bit 0 ... OL at bit
//   N_LANES-1) and puts them out on a single wire. Words are first held in a
//   small FIFO. Each word is then sent as one frame of N_LANES serial bits
//   with valid/ready flow control. A counter records how many frames have
//   been fully transmitted.
//
// Parameters
//   N_LANES    bits per word / beats per frame (>= 2)
//   DEPTH      FIFO depth in words (power of 2, >= 2)
//   MSB_FIRST  0: bit 0 is sent first; 1: bit N_LANES-1 is sent first
//   CNT_W      width of frame_cnt
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous, active-high reset
//   in_data    parallel lane word {OL..OA}
//   in_valid   in_data is valid
//   in_ready   FIFO can take a word (decoded from the registered fill level)
//   so         serial data bit (registered)
//   so_valid   so carries a valid bit (registered)
//   so_last    current bit is the last bit of its frame (registered)
//   so_ready   sink accepts the current bit
//   frame_cnt  frames fully transmitted, modulo 2^CNT_W
//
// Timing
//   A word pushed at edge t into an empty FIFO with an idle engine is popped
//   at edge t+1. Its first bit is valid after edge t+2. Consecutive frames
//   leave with no bubble between them while the FIFO holds words. Up to
//   DEPTH words sit in the FIFO, plus one word in the shift stage.
// -----------------------------------------------------------------------------
module lane_serializer #(
    parameter int N_LANES   = 12,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 0,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LANES-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               so,
    output logic               so_valid,
    output logic               so_last,
    input  logic               so_ready,
    output logic [CNT_W-1:0]   frame_cnt
);

    // -------------------------------------------------------------------------
    // Derived sizes
    // -------------------------------------------------------------------------
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FILL_W  = $clog2(DEPTH + 1);
    localparam int IDX_W   = $clog2(N_LANES);

    localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_LANES - 1);

    // Shift-engine states. LOAD exists so that the first bit of a frame
    // appears one edge after the pop. This keeps so/so_valid purely registered.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    // -------------------------------------------------------------------------
    // FIFO
    // -------------------------------------------------------------------------
    logic [N_LANES-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [FILL_W-1:0]  fill_reg;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic [N_LANES-1:0] head;

    // in_ready depends only on the registered fill level. A full FIFO
    // therefore refuses a word even when a pop happens on the same edge.
    assign in_ready   = (fill_reg != FULL_FILL);
    assign fifo_empty = (fill_reg == '0);
    assign push       = in_valid && in_ready;

    // The FIFO is only a few words deep, and the engine needs the head word
    // in the same cycle as the pop so that back-to-back frames have no gap.
    // For these reasons the head is read directly from the storage array.
    assign head = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fill_reg <= fill_reg + FILL_W'(1);
                2'b01:   fill_reg <= fill_reg - FILL_W'(1);
                default: fill_reg <= fill_reg;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Shift engine
    // -------------------------------------------------------------------------
    logic [1:0]         state_reg;
    logic [1:0]         state_next;
    logic [N_LANES-1:0] word_reg;
    logic [N_LANES-1:0] word_next;
    logic [IDX_W-1:0]   idx_reg;
    logic [IDX_W-1:0]   idx_next;
    logic               so_reg;
    logic               so_valid_reg;
    logic               so_last_reg;
    logic [CNT_W-1:0]   frame_cnt_reg;
    logic               accept;
    logic               frame_done;
    logic [N_LANES-1:0] ordered_next;
    logic               so_bit_next;
    logic               shifting_next;

    assign accept = so_valid_reg && so_ready;

    always_comb begin
        state_next = state_reg;
        word_next  = word_reg;
        idx_next   = idx_reg;
        pop        = 1'b0;
        frame_done = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    word_next  = head;
                    idx_next   = '0;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (accept) begin
                    if (so_last_reg) begin
                        frame_done = 1'b1;
                        if (!fifo_empty) begin
                            // Chain straight into the next frame.
                            pop       = 1'b1;
                            word_next = head;
                            idx_next  = '0;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Put the word in transmit order, so that the beat index selects the
    // bit directly whatever the bit order is.
    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_order
            if (MSB_FIRST != 0) begin : g_msb
                assign ordered_next[gi] = word_next[N_LANES-1-gi];
            end else begin : g_lsb
                assign ordered_next[gi] = word_next[gi];
            end
        end
    endgenerate

    assign shifting_next = (state_next == ST_SHIFT);
    assign so_bit_next   = ordered_next[idx_next];

    // During a stall, word, index and state do not change. The registered
    // outputs therefore reload the same values and hold steady.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            word_reg      <= '0;
            idx_reg       <= '0;
            so_reg        <= 1'b0;
            so_valid_reg  <= 1'b0;
            so_last_reg   <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            word_reg     <= word_next;
            idx_reg      <= idx_next;
            so_reg       <= shifting_next ? so_bit_next : 1'b0;
            so_valid_reg <= shifting_next;
            so_last_reg  <= shifting_next && (idx_next == LAST_IDX);
            if (frame_done) begin
                frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign so        = so_reg;
    assign so_valid  = so_valid_reg;
    assign so_last   = so_last_reg;
    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_lane_serializer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_lane_serializer
//
// Purpose
//   Self-checking bench for lane_serializer. Two instances share the same
//   inputs:
//     dut_a  bit 0 sent first, 16-bit frame counter
//     dut_b  bit N-1 sent first, 4-bit frame counter
//   A negedge monitor for each instance keeps its own model:
//     - a queue of the words accepted,
//     - the beat position inside the current frame,
//     - the number of frames completed.
//   Each bit sent must be the bit of the queued word that the bit-order rule
//   selects. Directed tables and sequences cover latency, back-pressure,
//   reset and counter wrap.
// -----------------------------------------------------------------------------
module tb_lane_serializer;

    localparam int NL = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NL-1:0] in_data;
    logic          in_valid;
    logic          so_ready;

    logic          in_ready_a, so_a, so_valid_a, so_last_a;
    logic [15:0]   frame_cnt_a;
    logic          in_ready_b, so_b, so_valid_b, so_last_b;
    logic [3:0]    frame_cnt_b;

    lane_serializer #(.N_LANES(NL), .DEPTH(4), .MSB_FIRST(0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_a), .so(so_a), .so_valid(so_valid_a),
        .so_last(so_last_a), .so_ready(so_ready), .frame_cnt(frame_cnt_a)
    );

    lane_serializer #(.N_LANES(NL), .DEPTH(4), .MSB_FIRST(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_b), .so(so_b), .so_valid(so_valid_b),
        .so_last(so_last_b), .so_ready(so_ready), .frame_cnt(frame_cnt_b)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // k-th transmitted bit of word w under the chosen bit order
    function automatic logic sent_bit(input logic [NL-1:0] w, input int k, input bit msb_first);
        logic [NL-1:0] v;
        v = msb_first ? (w >> (NL - 1 - k)) : (w >> k);
        return v[0];
    endfunction

    // ---------------------------------------------------------------- models
    logic [NL-1:0] q_a[$];
    logic [NL-1:0] q_b[$];
    int   nbit_a = 0, nbit_b = 0, frames_a = 0, frames_b = 0;
    logic stall_a = 0, stall_b = 0, hold_so_a = 0, hold_so_b = 0;
    logic hold_last_a = 0, hold_last_b = 0;

    always @(negedge clk) begin
        if (rst) begin
            q_a.delete(); nbit_a = 0; frames_a = 0; stall_a = 0;
        end else begin
            if (stall_a) begin
                check("stall_valid_a", so_valid_a, 1'b1);
                check("stall_so_a", so_a, hold_so_a);
                check("stall_last_a", so_last_a, hold_last_a);
            end
            check("frame_cnt_a", frame_cnt_a, frames_a[15:0]);
            if (so_valid_a) begin
                check("so_last_a", so_last_a, nbit_a == NL - 1);
                if (so_ready) begin
                    check("word_pending_a", q_a.size() != 0, 1'b1);
                    if (q_a.size() != 0) begin
                        check("so_bit_a", so_a, sent_bit(q_a[0], nbit_a, 1'b0));
                        nbit_a++;
                        if (nbit_a == NL) begin
                            void'(q_a.pop_front());
                            nbit_a = 0;
                            frames_a++;
                        end
                    end
                end
            end
            stall_a = so_valid_a && !so_ready;
            hold_so_a = so_a;
            hold_last_a = so_last_a;
            if (in_valid && in_ready_a) q_a.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q_b.delete(); nbit_b = 0; frames_b = 0; stall_b = 0;
        end else begin
            if (stall_b) begin
                check("stall_valid_b", so_valid_b, 1'b1);
                check("stall_so_b", so_b, hold_so_b);
                check("stall_last_b", so_last_b, hold_last_b);
            end
            check("frame_cnt_b", frame_cnt_b, frames_b % 16);
            if (so_valid_b) begin
                check("so_last_b", so_last_b, nbit_b == NL - 1);
                if (so_ready) begin
                    check("word_pending_b", q_b.size() != 0, 1'b1);
                    if (q_b.size() != 0) begin
                        check("so_bit_b", so_b, sent_bit(q_b[0], nbit_b, 1'b1));
                        nbit_b++;
                        if (nbit_b == NL) begin
                            void'(q_b.pop_front());
                            nbit_b = 0;
                            frames_b++;
                        end
                    end
                end
            end
            stall_b = so_valid_b && !so_ready;
            hold_so_b = so_b;
            hold_last_b = so_last_b;
            if (in_valid && in_ready_b) q_b.push_back(in_data);
        end
    end

    // ------------------------------------------------------------- helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cycles);
        so_ready = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (q_a.size() == 0 && q_b.size() == 0 && !so_valid_a && !so_valid_b) break;
            step();
        end
        check("drain_empty_a", q_a.size(), 0);
        check("drain_empty_b", q_b.size(), 0);
        check("drain_idle_a", so_valid_a, 1'b0);
    endtask

    // ------------------------------------------------------------- vectors
    typedef struct {
        logic [NL-1:0] word;
        logic [NL-1:0] seq_lsb;   // bit k = k-th bit on the wire, bit 0 first
        logic [NL-1:0] seq_msb;   // bit k = k-th bit on the wire, bit 11 first
    } vec_t;

    vec_t vecs[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        logic [NL-1:0] seq_a, seq_b;
        int cyc, acc, pushed, nf;
        logic acc_last;

        vecs[0] = '{12'hA5C, 12'hA5C, 12'h3A5};
        vecs[1] = '{12'hFFF, 12'hFFF, 12'hFFF};
        vecs[2] = '{12'h001, 12'h001, 12'h800};
        vecs[3] = '{12'h800, 12'h800, 12'h001};
        vecs[4] = '{12'h555, 12'h555, 12'hAAA};
        vecs[5] = '{12'h0F0, 12'h0F0, 12'h0F0};
        vecs[6] = '{12'h123, 12'h123, 12'hC48};

        in_data = '0; in_valid = 1'b0; so_ready = 1'b0; rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // ---- reset state
        check("rst_in_ready_a", in_ready_a, 1'b1);
        check("rst_in_ready_b", in_ready_b, 1'b1);
        check("rst_so_valid_a", so_valid_a, 1'b0);
        check("rst_so_a", so_a, 1'b0);
        check("rst_so_last_a", so_last_a, 1'b0);
        check("rst_frame_cnt_a", frame_cnt_a, 16'd0);
        check("rst_frame_cnt_b", frame_cnt_b, 4'd0);
        step();

        // ---- single frames from the table: latency, bit order, last flag
        for (int i = 0; i < 7; i++) begin
            seq_a = vecs[i].seq_lsb;
            seq_b = vecs[i].seq_msb;
            in_data = vecs[i].word; in_valid = 1'b1; so_ready = 1'b1;
            step();                                   // edge t: push
            in_valid = 1'b0;
            check("lat_t_a", so_valid_a, 1'b0);
            step();                                   // edge t+1: pop
            check("lat_t1_a", so_valid_a, 1'b0);
            check("lat_t1_b", so_valid_b, 1'b0);
            step();                                   // edge t+2: first bit
            for (int k = 0; k < NL; k++) begin
                check("vec_valid_a", so_valid_a, 1'b1);
                check("vec_so_a", so_a, seq_a[k]);
                check("vec_last_a", so_last_a, k == NL - 1);
                check("vec_so_b", so_b, seq_b[k]);
                check("vec_last_b", so_last_b, k == NL - 1);
                step();
            end
            check("vec_end_valid_a", so_valid_a, 1'b0);
            check("vec_cnt_a", frame_cnt_a, i + 1);
            check("vec_cnt_b", frame_cnt_b, i + 1);
        end

        // ---- back-to-back frames FFF then 001: no bubble
        in_data = 12'hFFF; in_valid = 1'b1; so_ready = 1'b1;
        step();
        in_data = 12'h001;
        step();
        in_valid = 1'b0;
        for (int w = 0; w < 5 && !so_valid_a; w++) step();
        check("b2b_start_a", so_valid_a, 1'b1);
        for (int k = 0; k < 2 * NL; k++) begin
            check("b2b_valid_a", so_valid_a, 1'b1);
            check("b2b_last_a", so_last_a, (k == NL - 1) || (k == 2 * NL - 1));
            if (k >= NL) check("b2b_second_so_a", so_a, k == NL);
            step();
        end
        check("b2b_end_valid_a", so_valid_a, 1'b0);
        check("b2b_cnt_a", frame_cnt_a, 16'd9);

        // ---- capacity under back-pressure: DEPTH+1 words accepted
        so_ready = 1'b0; acc = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = 1'b1; in_data = NL'($urandom);
            if (in_ready_a) acc++;
            step();
        end
        in_valid = 1'b0;
        check("cap_accepted", acc, 5);
        check("cap_in_ready_a", in_ready_a, 1'b0);
        check("cap_in_ready_b", in_ready_b, 1'b0);
        so_ready = 1'b1;
        cyc = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (in_ready_a) begin cyc = c; break; end
        end
        check("cap_ready_return_cycles", cyc, 12);
        drain(120);

        // ---- random back-pressure, 20 random words
        pushed = 0;
        for (int c = 0; c < 3000 && pushed < 20; c++) begin
            so_ready = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            in_data = NL'($urandom);
            if (in_valid && in_ready_a) pushed++;
            step();
        end
        in_valid = 1'b0;
        check("rand_pushed", pushed, 20);
        drain(400);

        // ---- reset mid-frame, with words still buffered
        so_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_data = NL'($urandom);
            step();
        end
        in_valid = 1'b0;
        for (int w = 0; w < 5 && !so_valid_a; w++) step();
        check("mid_start_a", so_valid_a, 1'b1);
        repeat (5) step();                            // five bits accepted
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid_a", so_valid_a, 1'b0);
        check("mid_rst_valid_b", so_valid_b, 1'b0);
        check("mid_rst_last_a", so_last_a, 1'b0);
        check("mid_rst_cnt_a", frame_cnt_a, 16'd0);
        check("mid_rst_ready_a", in_ready_a, 1'b1);
        #4 rst = 1'b0;
        step();
        for (int c = 0; c < 3; c++) begin
            check("mid_discarded_a", so_valid_a, 1'b0);
            step();
        end
        in_valid = 1'b1; in_data = 12'h6B3;
        step();
        in_valid = 1'b0;
        repeat (18) step();
        check("mid_clean_cnt_a", frame_cnt_a, 16'd1);
        check("mid_clean_cnt_b", frame_cnt_b, 4'd1);
        check("mid_clean_q_a", q_a.size(), 0);

        // ---- 4-bit frame counter wrap over 17 frames
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("wrap_rst_cnt_b", frame_cnt_b, 4'd0);
        so_ready = 1'b1; pushed = 0; nf = 0;
        for (int c = 0; c < 400 && nf < 17; c++) begin
            in_valid = (pushed < 17);
            in_data = NL'($urandom);
            if (in_valid && in_ready_b) pushed++;
            acc_last = so_valid_b && so_ready && so_last_b;
            step();
            if (acc_last) begin
                nf++;
                if (nf == 15) check("wrap_cnt_15", frame_cnt_b, 4'd15);
                if (nf == 16) check("wrap_cnt_16", frame_cnt_b, 4'd0);
                if (nf == 17) check("wrap_cnt_17", frame_cnt_b, 4'd1);
            end
        end
        in_valid = 1'b0;
        check("wrap_frames_seen", nf, 17);
        check("wrap_cnt_a", frame_cnt_a, 16'd17);
        drain(60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
